// File: rtl/regfile_arbiter.sv
// Two-requester arbiter in front of an 8x8 register file. It clears all entries after reset.
// Defining REGFILE_ARB_ROUND_ROBIN_EN selects round-robin contention; the default is fixed priority to requester 0.
module regfile_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req0_we,
  input  logic [2:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic       req0_ready,
  output logic       req0_rvalid,
  output logic [7:0] req0_rdata,
  input  logic       req1_valid,
  input  logic       req1_we,
  input  logic [2:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       req1_ready,
  output logic       req1_rvalid,
  output logic [7:0] req1_rdata,
  output logic       rf_write_en,
  output logic [2:0] rf_write_addr,
  output logic [7:0] rf_data_in,
  output logic [2:0] rf_read_addr,
  input  logic [7:0] rf_data_out,
  output logic       init_done
);

  typedef enum logic {INIT, RUN} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       init_done_q, init_done_d;
  logic       rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [7:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic       gnt0, gnt1;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  logic       prio_q, prio_d;  // requester that wins the next contention
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && state_q == RUN) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
      if (req0_valid && req1_valid) begin
        gnt0 = ~prio_q;
        gnt1 = prio_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
`else
      gnt0 = req0_valid;
      gnt1 = req1_valid && !req0_valid;
`endif
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    rf_write_en   = 1'b0;
    rf_write_addr = 3'd0;
    rf_data_in    = 8'd0;
    rf_read_addr  = 3'd0;
    if (!reset && state_q == INIT) begin
      rf_write_en   = 1'b1;
      rf_write_addr = cnt_q;
    end else if (gnt0) begin
      if (req0_we) begin
        rf_write_en   = 1'b1;
        rf_write_addr = req0_addr;
        rf_data_in    = req0_wdata;
      end else begin
        rf_read_addr  = req0_addr;
      end
    end else if (gnt1) begin
      if (req1_we) begin
        rf_write_en   = 1'b1;
        rf_write_addr = req1_addr;
        rf_data_in    = req1_wdata;
      end else begin
        rf_read_addr  = req1_addr;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rvalid0_d   = gnt0 && !req0_we;
    rvalid1_d   = gnt1 && !req1_we;
    rdata0_d    = (gnt0 && !req0_we) ? rf_data_out : rdata0_q;
    rdata1_d    = (gnt1 && !req1_we) ? rf_data_out : rdata1_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        state_d     = RUN;
        init_done_d = 1'b1;
      end
    end
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    prio_d = gnt0 ? 1'b1 : (gnt1 ? 1'b0 : prio_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      cnt_q       <= 3'd0;
      init_done_q <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= 8'd0;
      rdata1_q    <= 8'd0;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
      prio_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
      prio_q      <= prio_d;
`endif
    end
  end

  // A pulse already registered is suppressed while reset is held.
  assign req0_rvalid = rvalid0_q & ~reset;
  assign req1_rvalid = rvalid1_q & ~reset;
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;
  assign init_done   = init_done_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 8x8 register file attached.
module tb_regfile_arbiter;
  logic       clk, reset;
  logic       req0_valid, req0_we, req1_valid, req1_we;
  logic [2:0] req0_addr, req1_addr;
  logic [7:0] req0_wdata, req1_wdata;
  logic       req0_ready, req0_rvalid, req1_ready, req1_rvalid;
  logic [7:0] req0_rdata, req1_rdata;
  logic       rf_write_en, init_done;
  logic [2:0] rf_write_addr, rf_read_addr;
  logic [7:0] rf_data_in, rf_data_out;
  logic [7:0] mem [8];
  int errors = 0;
  int checks = 0;

  regfile_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_data_in(rf_data_in),
    .rf_read_addr(rf_read_addr), .rf_data_out(rf_data_out), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (rf_write_en) mem[rf_write_addr] <= rf_data_in;
  assign rf_data_out = mem[rf_read_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    repeat (10) tick();
    req0_valid = 1;
    #1;
    checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", rf_write_en); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0 got %b exp 0", req0_ready); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got %b exp 0", init_done); end
    checks++; if (req0_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata0 got %h exp 00", req0_rdata); end
    tick();
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (rf_write_en !== 1'b1 || rf_write_addr !== i[2:0] || rf_data_in !== 8'h00)
        begin errors++; $display("FAIL clear_%0d got we=%b addr=%0d data=%h exp we=1 addr=%0d data=00", i, rf_write_en, rf_write_addr, rf_data_in, i); end
      checks++; if (req0_ready !== 1'b0 || init_done !== 1'b0)
        begin errors++; $display("FAIL clear_ctrl_%0d got ready0=%b init_done=%b exp 0 0", i, req0_ready, init_done); end
      tick();
    end
    req0_valid = 0;
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done got %b exp 1", init_done); end
  endtask

  task automatic test_write_read();
    req0_valid = 1; req0_we = 1; req0_addr = 3'd3; req0_wdata = 8'hA5;
    #1;
    checks++; if (req0_ready !== 1'b1 || rf_write_en !== 1'b1 || rf_write_addr !== 3'd3 || rf_data_in !== 8'hA5)
      begin errors++; $display("FAIL wr0 got ready=%b we=%b addr=%0d data=%h exp 1 1 3 a5", req0_ready, rf_write_en, rf_write_addr, rf_data_in); end
    tick();
    idle_inputs();
    checks++; if (req0_rvalid !== 1'b0) begin errors++; $display("FAIL wr0_no_rvalid got %b exp 0", req0_rvalid); end
    req1_valid = 1; req1_addr = 3'd3;
    #1;
    checks++; if (req1_ready !== 1'b1 || rf_read_addr !== 3'd3 || rf_write_en !== 1'b0)
      begin errors++; $display("FAIL rd1 got ready=%b raddr=%0d we=%b exp 1 3 0", req1_ready, rf_read_addr, rf_write_en); end
    tick();
    idle_inputs();
    checks++; if (req1_rvalid !== 1'b1 || req1_rdata !== 8'hA5)
      begin errors++; $display("FAIL rd1_resp got rvalid=%b rdata=%h exp 1 a5", req1_rvalid, req1_rdata); end
    checks++; if (req0_rvalid !== 1'b0) begin errors++; $display("FAIL rd1_rvalid0 got %b exp 0", req0_rvalid); end
    tick();
    checks++; if (req1_rvalid !== 1'b0 || req1_rdata !== 8'hA5)
      begin errors++; $display("FAIL rd1_hold got rvalid=%b rdata=%h exp 0 a5", req1_rvalid, req1_rdata); end
    req1_valid = 1; req1_we = 1; req1_addr = 3'd5; req1_wdata = 8'h3C;
    #1;
    checks++; if (req1_ready !== 1'b1 || rf_write_addr !== 3'd5 || rf_data_in !== 8'h3C)
      begin errors++; $display("FAIL wr1 got ready=%b addr=%0d data=%h exp 1 5 3c", req1_ready, rf_write_addr, rf_data_in); end
    tick();
    idle_inputs();
  endtask

  task automatic test_contention();
    logic exp0;
    req0_valid = 1; req0_addr = 3'd5;
    req1_valid = 1; req1_addr = 3'd3;
    for (int i = 0; i < 4; i++) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
      exp0 = (i % 2 == 0);
`else
      exp0 = 1'b1;
`endif
      #1;
      checks++; if (req0_ready !== exp0 || req1_ready !== !exp0)
        begin errors++; $display("FAIL arb_%0d got ready0=%b ready1=%b exp %b %b", i, req0_ready, req1_ready, exp0, !exp0); end
      tick();
      if (exp0) begin
        checks++; if (req0_rvalid !== 1'b1 || req0_rdata !== 8'h3C || req1_rvalid !== 1'b0)
          begin errors++; $display("FAIL arb_resp0_%0d got rvalid0=%b rdata0=%h rvalid1=%b exp 1 3c 0", i, req0_rvalid, req0_rdata, req1_rvalid); end
      end else begin
        checks++; if (req1_rvalid !== 1'b1 || req1_rdata !== 8'hA5 || req0_rvalid !== 1'b0)
          begin errors++; $display("FAIL arb_resp1_%0d got rvalid1=%b rdata1=%h rvalid0=%b exp 1 a5 0", i, req1_rvalid, req1_rdata, req0_rvalid); end
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (rf_write_en !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || rf_read_addr !== 3'd0)
        begin errors++; $display("FAIL idle_ctrl_%0d got we=%b r0=%b r1=%b raddr=%0d exp 0 0 0 0", i, rf_write_en, req0_ready, req1_ready, rf_read_addr); end
      checks++; if (req0_rvalid !== 1'b0 || req1_rvalid !== 1'b0 || req0_rdata !== 8'h3C || req1_rdata !== 8'hA5)
        begin errors++; $display("FAIL idle_resp_%0d got rv0=%b rv1=%b d0=%h d1=%h exp 0 0 3c a5", i, req0_rvalid, req1_rvalid, req0_rdata, req1_rdata); end
      tick();
    end
  endtask

  task automatic test_reset_mid_init();
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1;
    #1;
    checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL midrst_we got %b exp 0", rf_write_en); end
    tick();
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (rf_write_en !== 1'b1 || rf_write_addr !== i[2:0] || init_done !== 1'b0)
        begin errors++; $display("FAIL reclear_%0d got we=%b addr=%0d done=%b exp 1 %0d 0", i, rf_write_en, rf_write_addr, init_done, i); end
      tick();
    end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL reclear_done got %b exp 1", init_done); end
  endtask

  task automatic test_reset_drop_rvalid();
    req0_valid = 1; req0_we = 1; req0_addr = 3'd2; req0_wdata = 8'h5A;
    tick();
    idle_inputs();
    req1_valid = 1; req1_addr = 3'd2;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL drop_grant got %b exp 1", req1_ready); end
    tick();
    idle_inputs();
    reset = 1;
    #1;
    checks++; if (req1_rvalid !== 1'b0) begin errors++; $display("FAIL drop_rvalid got %b exp 0", req1_rvalid); end
    tick();
    checks++; if (req1_rvalid !== 1'b0 || req1_rdata !== 8'h00 || init_done !== 1'b0)
      begin errors++; $display("FAIL drop_after got rvalid=%b rdata=%h done=%b exp 0 00 0", req1_rvalid, req1_rdata, init_done); end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_idle();
    test_reset_mid_init();
    test_reset_drop_rvalid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
